// File: rtl/data_mem_ctrl.sv
// Byte-addressed RV32 load/store front end for a 32-bit word SRAM; sub-word stores read-modify-write.
// Latency accept->rsp_valid: load 3, SW 2, SB/SH 4, error 1; one request in flight, no response backpressure.
module data_mem_ctrl #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wren,
    input  logic [31:0]          req_addr,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic                 sram_rden,
    output logic                 sram_wren,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READ    = 3'd1;
    localparam logic [2:0] MERGE   = 3'd2;
    localparam logic [2:0] EXTRACT = 3'd3;
    localparam logic [2:0] WRITE   = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;
    localparam logic [2:0] ERR     = 3'd6;

    logic [2:0]           state;
    logic [ADDR_BITS+1:0] addr_q;
    logic [2:0]           funct3_q;
    logic [31:0]          wdata_q;
    logic                 wren_q;
    logic [31:0]          rdata_q;
    logic [31:0]          wdata_out_q;
    logic                 req_ok;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [31:0]          extracted;
    logic [31:0]          merged;
    logic                 unused_addr_bits;

    // Address bits above the SRAM range are dropped, so accesses wrap.
    assign unused_addr_bits = ^req_addr[31:ADDR_BITS+2];

    always_comb begin
        req_ok = 1'b0;
        case (req_funct3)
            3'd0:       req_ok = 1'b1;
            3'd1:       req_ok = !req_addr[0];
            3'd2:       req_ok = (req_addr[1:0] == 2'b00);
            3'd4, 3'd5: req_ok = !req_wren;
            default:    req_ok = 1'b0;
        endcase
    end

    always_comb begin
        byte_sel  = sram_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = sram_rdata[{addr_q[1], 4'b0000} +: 16];
        extracted = sram_rdata;
        case (funct3_q)
            3'd0:    extracted = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    extracted = {{16{half_sel[15]}}, half_sel};
            3'd4:    extracted = {24'd0, byte_sel};
            3'd5:    extracted = {16'd0, half_sel};
            default: extracted = sram_rdata;
        endcase
        merged = sram_rdata;
        if (funct3_q[1:0] == 2'd0) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
            wren_q      <= 1'b0;
            rdata_q     <= '0;
            wdata_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr[ADDR_BITS+1:0];
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata;
                        wren_q   <= req_wren;
                        rdata_q  <= '0;
                        if (!req_ok) begin
                            state <= ERR;
                        end else if (req_wren && req_funct3 == 3'd2) begin
                            wdata_out_q <= req_wdata;
                            state       <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ:    state <= wren_q ? MERGE : EXTRACT;
                MERGE: begin
                    wdata_out_q <= merged;
                    state       <= WRITE;
                end
                EXTRACT: begin
                    rdata_q <= extracted;
                    state   <= RESP;
                end
                WRITE:   state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP) || (state == ERR);
    assign rsp_err    = (state == ERR);
    assign rsp_rdata  = (state == RESP) ? rdata_q : 32'd0;
    assign sram_addr  = addr_q[ADDR_BITS+1:2];
    assign sram_rden  = (state == READ);
    assign sram_wren  = (state == WRITE);
    assign sram_wdata = wdata_out_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: ADDR_BITS, 10, word-address width of the attached SRAM (1024 x 32-bit words).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core presents a memory request.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_wren  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_funct3  input  3  RV32 load/store funct3.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  request rejected; valid with rsp_valid.
REQ-013 sram_addr  output  ADDR_BITS  SRAM word address.
REQ-014 sram_rden  output  1  SRAM read strobe.
REQ-015 sram_wren  output  1  SRAM write strobe.
REQ-016 sram_wdata  output  32  SRAM write word.
REQ-017 sram_rdata  input  32  SRAM read word; valid the cycle after sram_rden and held until the next read.

Function
REQ-018 States SHALL be IDLE, READ, MERGE, EXTRACT, WRITE, RESP, ERR.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge with req_valid=1 and req_ready=1, latching addr, funct3, wdata and wren.
REQ-020 Every output other than req_ready SHALL be driven from registered state or latched request fields only, with no combinational path from req_*.
REQ-021 sram_addr SHALL equal latched addr[ADDR_BITS+1:2]; upper address bits are ignored, so addresses wrap modulo 4*2^ADDR_BITS.
REQ-022 Valid loads are funct3 0 (LB), 1 (LH), 2 (LW), 4 (LBU) and 5 (LHU); valid stores are 0 (SB), 1 (SH) and 2 (SW).
REQ-023 An invalid funct3, a halfword with addr[0]=1, or a word with addr[1:0]!=0 SHALL go IDLE->ERR->IDLE with no SRAM strobe.
  - ERR drives rsp_valid=1, rsp_err=1 and rsp_rdata=0.
REQ-024 A valid load SHALL take IDLE->READ->EXTRACT->RESP->IDLE.
  - READ drives sram_rden=1.
  - EXTRACT registers the selected byte/half from sram_rdata (lane = addr[1:0] or addr[1]), sign-extended for funct3 0/1 and zero-extended for 4/5.
REQ-025 SW SHALL take IDLE->WRITE->RESP->IDLE, with sram_wdata = wdata.
REQ-026 SB and SH SHALL take IDLE->READ->MERGE->WRITE->RESP->IDLE.
  - MERGE registers sram_rdata with only the addressed byte/half lanes replaced by wdata[7:0] or wdata[15:0].
  - WRITE drives sram_wren=1 with the merged word.
REQ-027 RESP SHALL drive rsp_valid=1 and rsp_err=0 for exactly one cycle; rsp_rdata is the extracted load value, or 0 for stores.
REQ-028 Latency from the accepting edge to rsp_valid high SHALL be: load 3 cycles, SW 2, SB/SH 4, error 1.
REQ-029 sram_rden and sram_wren SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per request.
REQ-030 There is no response backpressure; the next request can be accepted no earlier than the edge after RESP/ERR.
REQ-031 req_valid/req_* changes while not in IDLE SHALL be ignored.

Reset
REQ-032 While reset=0 the block SHALL force IDLE asynchronously.
  - Outputs: req_ready=1 after release, and rsp_valid, rsp_err, sram_rden, sram_wren = 0.
  - Data: rsp_rdata, sram_wdata and latched fields = 0; sram_addr = 0.
REQ-033 Reset asserted mid-request SHALL abandon it.
  - A sub-word store reset before WRITE SHALL leave SRAM unmodified.
  - No rsp_valid SHALL be produced for the abandoned request.

Verification
REQ-034 SRAM word 5 = 0x8899AABB; LB addr 0x16 -> rsp_rdata 0xFFFFFF99 three cycles after accept; LBU addr 0x16 -> 0x00000099.
REQ-035 SRAM word 5 = 0x8899AABB; SH wdata 0x1234 addr 0x16 -> one sram_wren with sram_wdata 0x1234AABB at address 5, rsp_valid 4 cycles after accept, rsp_rdata 0.
REQ-036 SW addr 0x100 wdata 0xDEADBEEF -> sram_wren at address 0x40 with 0xDEADBEEF, no sram_rden, rsp_valid 2 cycles after accept.
REQ-037 LW addr 0x102; SH addr 0x03; load funct3=3 -> each gives rsp_valid+rsp_err one cycle after accept, rsp_rdata 0, no SRAM strobe.
REQ-038 LW addr 0x1004 with ADDR_BITS=10 -> reads word address 1 (wrap).
REQ-039 SB issued, reset pulsed in the MERGE cycle -> no sram_wren, no rsp_valid, SRAM unchanged, req_ready=1 after release, and the next LW returns the original word.
